// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the Pong game sequencer and its environment.
// The environment is the VGA timing block, the input synchroniser and the ball datapath.
//
// Signals:
//   frame_tick  : one-cycle pulse per video frame
//   start_btn   : debounced start/serve request, level
//   miss_left   : ball passed the left boundary (pulse)
//   miss_right  : ball passed the right boundary (pulse)
//   paddle_hit  : ball bounced off a paddle (pulse)
//   ball_load   : reload ball to centre (pulse)
//   ball_dir    : serve direction latched on ball_load (0=left, 1=right)
//   ball_step   : apply one velocity step (pulse)
//   ball_speed  : speed level for velocity scaling
//   score_left  : left player score
//   score_right : right player score
//   game_state  : registered FSM state encoding
//   game_over   : high while the game is over
//
// Modports:
//   master : the sequencer side (drives the ball/score/status outputs)
//   slave  : the environment side (drives the tick/button/event inputs)
interface pong_game_ctrl_if;
    logic       frame_tick;
    logic       start_btn;
    logic       miss_left;
    logic       miss_right;
    logic       paddle_hit;
    logic       ball_load;
    logic       ball_dir;
    logic       ball_step;
    logic [1:0] ball_speed;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic [2:0] game_state;
    logic       game_over;

    modport master (
        input  frame_tick, start_btn, miss_left, miss_right, paddle_hit,
        output ball_load, ball_dir, ball_step, ball_speed,
               score_left, score_right, game_state, game_over
    );

    modport slave (
        output frame_tick, start_btn, miss_left, miss_right, paddle_hit,
        input  ball_load, ball_dir, ball_step, ball_speed,
               score_left, score_right, game_state, game_over
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game-level sequencer.
// It decides when the ball steps, when it is re-centred and in which direction it serves.
// It also keeps both scores and flags game over.
//
// Optional feature macro: PONG_SPEEDUP_EN
//   When defined, every 4 paddle hits in PLAY raise ball_speed by one, saturating at 3.
//   When undefined, ball_speed is tied to 0 and paddle_hit is ignored.
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : pong_game_ctrl_if.master (tick/button/event inputs, ball/score/status outputs)
//
// Parameters:
//   STEP_DIV    : frame ticks per ball step (1..15)
//   WIN_SCORE   : points needed to win (1..15)
//   SERVE_DELAY : frame ticks spent in SERVE (1..255)
module pong_game_ctrl #(
    parameter int STEP_DIV    = 1,
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 60
) (
    input  logic               clk,
    input  logic               rst_n,
    pong_game_ctrl_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_e;

    localparam logic [7:0] SERVE_LAST = 8'(SERVE_DELAY - 1);
    localparam logic [3:0] STEP_LAST  = 4'(STEP_DIV - 1);
    localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);

    // Scores stop at 15 instead of wrapping back to 0.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? 4'hF : (v + 4'd1);
    endfunction

    state_e     state_q, state_d;
    logic [7:0] serve_cnt_q, serve_cnt_d;
    logic [3:0] div_q, div_d;
    logic [3:0] score_l_q, score_l_d;
    logic [3:0] score_r_q, score_r_d;
    logic       dir_q, dir_d;
    logic       load_q, load_d;
    logic       step_q, step_d;
    logic       over_q, over_d;
    logic       start_prev_q;

    // Next-state and strobe decode.
    // Counters default to 0, so they clear whenever their state is left or entered.
    always_comb begin
        state_d     = state_q;
        serve_cnt_d = 8'd0;
        div_d       = 4'd0;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        dir_d       = dir_q;
        load_d      = 1'b0;
        step_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start_btn) begin
                    state_d   = S_SERVE;
                    load_d    = 1'b1;
                    dir_d     = 1'b1;
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SERVE: begin
                if (bus.frame_tick) begin
                    if (serve_cnt_q == SERVE_LAST) begin
                        state_d = S_PLAY;
                    end else begin
                        serve_cnt_d = serve_cnt_q + 8'd1;
                    end
                end else begin
                    serve_cnt_d = serve_cnt_q;
                end
            end
            S_PLAY: begin
                // A miss outranks a coincident frame tick, and miss_left outranks miss_right.
                if (bus.miss_left) begin
                    score_r_d = sat_inc4(score_r_q);
                    dir_d     = 1'b0;
                    state_d   = S_POINT;
                end else if (bus.miss_right) begin
                    score_l_d = sat_inc4(score_l_q);
                    dir_d     = 1'b1;
                    state_d   = S_POINT;
                end else if (bus.frame_tick) begin
                    if (div_q == STEP_LAST) begin
                        step_d = 1'b1;
                    end else begin
                        div_d = div_q + 4'd1;
                    end
                end else begin
                    div_d = div_q;
                end
            end
            S_POINT: begin
                if ((score_l_q == WIN_VAL) || (score_r_q == WIN_VAL)) begin
                    state_d = S_OVER;
                end else begin
                    load_d  = 1'b1;
                    state_d = S_SERVE;
                end
            end
            S_OVER: begin
                // Only a fresh press leaves OVER; a button held through the final point is ignored.
                if (bus.start_btn && !start_prev_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OVER;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        over_d = (state_d == S_OVER);
    end

    // State, counters, scores and registered output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            serve_cnt_q  <= 8'd0;
            div_q        <= 4'd0;
            score_l_q    <= 4'd0;
            score_r_q    <= 4'd0;
            dir_q        <= 1'b0;
            load_q       <= 1'b0;
            step_q       <= 1'b0;
            over_q       <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            serve_cnt_q  <= serve_cnt_d;
            div_q        <= div_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            dir_q        <= dir_d;
            load_q       <= load_d;
            step_q       <= step_d;
            over_q       <= over_d;
            start_prev_q <= bus.start_btn;
        end
    end

`ifdef PONG_SPEEDUP_EN
    logic [1:0] hit_q, hit_d;
    logic [1:0] speed_q, speed_d;

    // Hit counter and speed level: one speed step per counter wrap, cleared between rallies.
    always_comb begin
        hit_d   = hit_q;
        speed_d = speed_q;
        if ((state_q == S_IDLE) || (state_q == S_POINT)) begin
            hit_d   = 2'd0;
            speed_d = 2'd0;
        end else if ((state_q == S_PLAY) && bus.paddle_hit && !bus.miss_left && !bus.miss_right) begin
            hit_d = hit_q + 2'd1;
            if ((hit_q == 2'd3) && (speed_q != 2'd3)) begin
                speed_d = speed_q + 2'd1;
            end else begin
                speed_d = speed_q;
            end
        end else begin
            hit_d   = hit_q;
            speed_d = speed_q;
        end
    end

    // Hit counter and speed registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q   <= 2'd0;
            speed_q <= 2'd0;
        end else begin
            hit_q   <= hit_d;
            speed_q <= speed_d;
        end
    end

    assign bus.ball_speed = speed_q;
`else
    logic unused_paddle_hit_s;
    assign unused_paddle_hit_s = bus.paddle_hit;
    assign bus.ball_speed      = 2'b00;
`endif

    assign bus.ball_load   = load_q;
    assign bus.ball_dir    = dir_q;
    assign bus.ball_step   = step_q;
    assign bus.score_left  = score_l_q;
    assign bus.score_right = score_r_q;
    assign bus.game_state  = state_q;
    assign bus.game_over   = over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed testbench for pong_game_ctrl.
// dut_a : STEP_DIV=2, WIN_SCORE=2, SERVE_DELAY=3 (serve, stepping, miss priority, game over)
// dut_b : STEP_DIV=1, WIN_SCORE=7, SERVE_DELAY=1 (speed-up, reset in the middle of PLAY)
module tb_pong_game_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pong_game_ctrl_if bus_a ();
    pong_game_ctrl_if bus_b ();

    pong_game_ctrl #(.STEP_DIV(2), .WIN_SCORE(2), .SERVE_DELAY(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    pong_game_ctrl #(.STEP_DIV(1), .WIN_SCORE(7), .SERVE_DELAY(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int step_a = 0;
    int load_a = 0;
    int base_cnt;

    // Pulse counters for dut_a strobes, sampled at every active edge.
    always @(posedge clk) begin
        if (bus_a.ball_step === 1'b1) step_a++;
        if (bus_a.ball_load === 1'b1) load_a++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        bus_a.frame_tick = 1'b0; bus_a.start_btn = 1'b0; bus_a.miss_left = 1'b0;
        bus_a.miss_right = 1'b0; bus_a.paddle_hit = 1'b0;
        bus_b.frame_tick = 1'b0; bus_b.start_btn = 1'b0; bus_b.miss_left = 1'b0;
        bus_b.miss_right = 1'b0; bus_b.paddle_hit = 1'b0;
    endtask

    // Three frame ticks take dut_a from SERVE into PLAY.
    task automatic a_serve();
        for (int k = 0; k < 3; k++) begin
            bus_a.frame_tick = 1'b1; cyc(); bus_a.frame_tick = 1'b0; cyc();
        end
        chk("a_serve_to_play", int'(bus_a.game_state), 2);
    endtask

    // One rally on dut_b: a tick into PLAY, then the given miss, POINT, and back to SERVE.
    task automatic b_point(input logic ml, input logic mr);
        bus_b.frame_tick = 1'b1; cyc(); bus_b.frame_tick = 1'b0;
        chk("b_play", int'(bus_b.game_state), 2);
        bus_b.miss_left = ml; bus_b.miss_right = mr; cyc();
        bus_b.miss_left = 1'b0; bus_b.miss_right = 1'b0;
        chk("b_point", int'(bus_b.game_state), 3);
        cyc();
        chk("b_reserve_state", int'(bus_b.game_state), 1);
        chk("b_reserve_load", int'(bus_b.ball_load), 1);
    endtask

    initial begin
        clr_inputs();
        rst_n = 1'b0;
        repeat (3) cyc();
        chk("rst_state", int'(bus_a.game_state), 0);
        chk("rst_scores", int'({bus_a.score_left, bus_a.score_right}), 0);
        chk("rst_strobes", int'({bus_a.ball_load, bus_a.ball_step, bus_a.ball_dir, bus_a.game_over}), 0);
        chk("rst_speed", int'(bus_a.ball_speed), 0);
        rst_n = 1'b1;
        cyc();
        chk("idle_hold", int'(bus_a.game_state), 0);

        // ---------------- dut_b: speed-up, then reset mid-PLAY at 3-2 ----------------
        bus_b.start_btn = 1'b1; cyc(); bus_b.start_btn = 1'b0;
        chk("b_start_state", int'(bus_b.game_state), 1);
        chk("b_start_load", int'(bus_b.ball_load), 1);
        chk("b_start_dir", int'(bus_b.ball_dir), 1);
        bus_b.frame_tick = 1'b1; cyc(); bus_b.frame_tick = 1'b0;
        chk("b_enter_play", int'(bus_b.game_state), 2);
        chk("b_no_step_serve", int'(bus_b.ball_step), 0);
        bus_b.frame_tick = 1'b1; cyc(); bus_b.frame_tick = 1'b0;
        chk("b_step_div1", int'(bus_b.ball_step), 1);
        for (int i = 0; i < 9; i++) begin
            bus_b.paddle_hit = 1'b1; cyc(); bus_b.paddle_hit = 1'b0; cyc();
        end
`ifdef PONG_SPEEDUP_EN
        chk("b_speed_9hits", int'(bus_b.ball_speed), 2);
`else
        chk("b_speed_9hits", int'(bus_b.ball_speed), 0);
`endif
        bus_b.miss_right = 1'b1; cyc(); bus_b.miss_right = 1'b0;
        chk("b_miss_point", int'(bus_b.game_state), 3);
        cyc();
        chk("b_speed_clear", int'(bus_b.ball_speed), 0);
        chk("b_back_serve", int'(bus_b.game_state), 1);
        b_point(1'b0, 1'b1);
        b_point(1'b0, 1'b1);
        b_point(1'b1, 1'b0);
        b_point(1'b1, 1'b0);
        bus_b.frame_tick = 1'b1; cyc(); bus_b.frame_tick = 1'b0;
        chk("b_score_left_3", int'(bus_b.score_left), 3);
        chk("b_score_right_2", int'(bus_b.score_right), 2);
        chk("b_in_play", int'(bus_b.game_state), 2);
        // A tick is pending when reset hits in the middle of the cycle.
        bus_b.frame_tick = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("b_async_rst_state", int'(bus_b.game_state), 0);
        chk("b_async_rst_scores", int'({bus_b.score_left, bus_b.score_right}), 0);
        cyc();
        chk("b_rst_state", int'(bus_b.game_state), 0);
        chk("b_rst_step", int'(bus_b.ball_step), 0);
        chk("b_rst_load", int'(bus_b.ball_load), 0);
        clr_inputs();
        rst_n = 1'b1;
        cyc();

        // ---------------- dut_a: serve, stepping, miss priority, game over ----------------
        bus_a.start_btn = 1'b1; cyc(); bus_a.start_btn = 1'b0;
        chk("a_start_state", int'(bus_a.game_state), 1);
        chk("a_start_load", int'(bus_a.ball_load), 1);
        chk("a_start_dir", int'(bus_a.ball_dir), 1);
        cyc();
        chk("a_load_one_cycle", int'(bus_a.ball_load), 0);
        base_cnt = step_a;
        for (int k = 0; k < 3; k++) begin
            bus_a.frame_tick = 1'b1; cyc(); bus_a.frame_tick = 1'b0;
            chk("a_serve_state", int'(bus_a.game_state), (k == 2) ? 2 : 1);
            cyc();
        end
        chk("a_serve_no_steps", step_a - base_cnt, 0);

        base_cnt = step_a;
        for (int i = 1; i <= 10; i++) begin
            bus_a.frame_tick = 1'b1; cyc(); bus_a.frame_tick = 1'b0;
            chk("a_play_step", int'(bus_a.ball_step), (i % 2 == 0) ? 1 : 0);
            cyc();
        end
        cyc();
        chk("a_step_total", step_a - base_cnt, 5);

        // Divider at 1: the next tick would step, but a coincident miss wins.
        bus_a.frame_tick = 1'b1; cyc(); bus_a.frame_tick = 1'b0; cyc();
        bus_a.frame_tick = 1'b1; bus_a.miss_left = 1'b1; bus_a.miss_right = 1'b1; cyc();
        clr_inputs();
        chk("a_dual_miss_no_step", int'(bus_a.ball_step), 0);
        chk("a_dual_miss_state", int'(bus_a.game_state), 3);
        chk("a_dual_miss_right", int'(bus_a.score_right), 1);
        chk("a_dual_miss_left", int'(bus_a.score_left), 0);
        chk("a_dual_miss_dir", int'(bus_a.ball_dir), 0);
        cyc();
        chk("a_reserve_state", int'(bus_a.game_state), 1);
        chk("a_reserve_load", int'(bus_a.ball_load), 1);
        chk("a_reserve_dir", int'(bus_a.ball_dir), 0);
        chk("a_reserve_no_step", int'(bus_a.ball_step), 0);
        bus_a.miss_left = 1'b1; cyc(); bus_a.miss_left = 1'b0;
        chk("a_miss_in_serve", int'(bus_a.score_right), 1);

        a_serve();
        bus_a.miss_right = 1'b1; cyc(); bus_a.miss_right = 1'b0;
        chk("a_mr1_left", int'(bus_a.score_left), 1);
        chk("a_mr1_dir", int'(bus_a.ball_dir), 1);
        cyc();
        chk("a_mr1_load", int'(bus_a.ball_load), 1);
        a_serve();
        // Button pressed before the winning point and held through it.
        bus_a.start_btn = 1'b1; bus_a.miss_right = 1'b1; cyc(); bus_a.miss_right = 1'b0;
        chk("a_mr2_left", int'(bus_a.score_left), 2);
        chk("a_mr2_point", int'(bus_a.game_state), 3);
        base_cnt = load_a;
        cyc();
        chk("a_over_state", int'(bus_a.game_state), 4);
        chk("a_over_flag", int'(bus_a.game_over), 1);
        chk("a_over_no_load", int'(bus_a.ball_load), 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("a_held_stays_over", int'(bus_a.game_state), 4);
        end
        bus_a.miss_left = 1'b1; cyc(); bus_a.miss_left = 1'b0;
        chk("a_miss_in_over", int'(bus_a.score_right), 1);
        chk("a_over_loads", load_a - base_cnt, 0);
        bus_a.start_btn = 1'b0; cyc();
        chk("a_released_over", int'(bus_a.game_state), 4);
        bus_a.start_btn = 1'b1; cyc(); bus_a.start_btn = 1'b0;
        chk("a_repress_idle", int'(bus_a.game_state), 0);
        chk("a_idle_over_flag", int'(bus_a.game_over), 0);
        cyc();
        chk("a_idle_stays", int'(bus_a.game_state), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
